cp0_core: RTL and testbench

Parametrised second-generation coprocessor 0 for the MIPS pipeline. Holds Status, Cause, EPC, BadVAddr and an optional Count/Compare timer. Prioritises exceptions and masked hardware interrupts, and commits exception entry and ERET return. Sits beside the ID/EX stage, drives the PC-override mux, and serves MFC0/MTC0.

---
 rtl/cp0_pkg.sv | 66 ++++++
 rtl/cp0_exc_prio.sv | 41 ++++
 rtl/cp0_core.sv | 203 ++++++++++++++++++++
 tb/tb_cp0_core.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, ExcCodes, Status/Cause bit
// positions, the priority-encoder result payload and register pack helpers.
package cp0_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned SEL_W  = 3;
  localparam int unsigned CODE_W = 5;
  localparam int unsigned IP_W   = 8;

  // CP0 register numbers (sel 0)
  localparam logic [REG_W-1:0] REG_BADVADDR = 5'd8;
  localparam logic [REG_W-1:0] REG_COUNT    = 5'd9;
  localparam logic [REG_W-1:0] REG_COMPARE  = 5'd11;
  localparam logic [REG_W-1:0] REG_STATUS   = 5'd12;
  localparam logic [REG_W-1:0] REG_CAUSE    = 5'd13;
  localparam logic [REG_W-1:0] REG_EPC      = 5'd14;

  // ExcCode values
  localparam logic [CODE_W-1:0] EXC_INT  = 5'd0;
  localparam logic [CODE_W-1:0] EXC_ADDR = 5'd4;
  localparam logic [CODE_W-1:0] EXC_SYS  = 5'd8;
  localparam logic [CODE_W-1:0] EXC_BP   = 5'd9;
  localparam logic [CODE_W-1:0] EXC_RI   = 5'd10;
  localparam logic [CODE_W-1:0] EXC_OV   = 5'd12;
  localparam logic [CODE_W-1:0] EXC_TR   = 5'd13;

  // Status bit positions
  localparam int unsigned ST_IE     = 0;
  localparam int unsigned ST_EXL    = 1;
  localparam int unsigned ST_UM     = 4;
  localparam int unsigned ST_IM_LSB = 8;

  // Cause bit positions
  localparam int unsigned CA_EXC_LSB = 2;
  localparam int unsigned CA_IP_LSB  = 8;
  localparam int unsigned CA_BD      = 31;

  typedef struct packed {
    logic              taken;
    logic              addr_err;
    logic [CODE_W-1:0] code;
  } exc_sel_t;

  function automatic logic [XLEN-1:0] pack_status(input logic ie, input logic exl,
                                                  input logic um, input logic [IP_W-1:0] im);
    logic [XLEN-1:0] v;
    v                     = '0;
    v[ST_IE]              = ie;
    v[ST_EXL]             = exl;
    v[ST_UM]              = um;
    v[ST_IM_LSB +: IP_W]  = im;
    return v;
  endfunction

  function automatic logic [XLEN-1:0] pack_cause(input logic bd, input logic [IP_W-1:0] ip,
                                                 input logic [CODE_W-1:0] code);
    logic [XLEN-1:0] v;
    v                        = '0;
    v[CA_BD]                 = bd;
    v[CA_IP_LSB +: IP_W]     = ip;
    v[CA_EXC_LSB +: CODE_W]  = code;
    return v;
  endfunction

endpackage

// File: rtl/cp0_exc_prio.sv
// Combinational exception priority encoder.
// Inputs : per-instruction exception requests and the masked interrupt pending flag.
// Output : exc_c = {taken, addr_err, ExcCode} of the highest-priority request.
module cp0_exc_prio
  import cp0_pkg::*;
(
  input  logic     addr_err,
  input  logic     ri,
  input  logic     ov,
  input  logic     tr,
  input  logic     sys,
  input  logic     bp,
  input  logic     int_pend,
  output exc_sel_t exc_c
);

  // Highest priority first; interrupts only when no synchronous exception.
  always_comb begin
    exc_c       = '0;
    exc_c.taken = 1'b1;
    if (addr_err) begin
      exc_c.code     = EXC_ADDR;
      exc_c.addr_err = 1'b1;
    end else if (ri) begin
      exc_c.code = EXC_RI;
    end else if (ov) begin
      exc_c.code = EXC_OV;
    end else if (tr) begin
      exc_c.code = EXC_TR;
    end else if (sys) begin
      exc_c.code = EXC_SYS;
    end else if (bp) begin
      exc_c.code = EXC_BP;
    end else if (int_pend) begin
      exc_c.code = EXC_INT;
    end else begin
      exc_c.taken = 1'b0;
    end
  end

endmodule

// File: rtl/cp0_core.sv
// Coprocessor 0: Status, Cause, EPC, BadVAddr and optional Count/Compare timer,
// exception/interrupt entry and ERET return, MFC0/MTC0 access.
// Optional feature macro: CP0_TIMER_EN (Count/Compare timer on Cause.IP[7]).
// Ports: clock/reset (sync, active-low); mfc0/mtc0/eret/rd/sel/reg_in -> reg_out;
//        int_in hardware interrupts; exc_* exception requests and context;
//        exc_pc_sel/exc_pc_out PC override; ip = Cause.IP; kernel_mode.
module cp0_core
  import cp0_pkg::*;
#(
  parameter int unsigned     NUM_HW_INT = 6,
  parameter logic [XLEN-1:0] EXC_VECTOR = 32'h8000_0180
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  mfc0,
  input  logic                  mtc0,
  input  logic                  eret,
  input  logic [REG_W-1:0]      rd,
  input  logic [SEL_W-1:0]      sel,
  input  logic [XLEN-1:0]       reg_in,
  output logic [XLEN-1:0]       reg_out,
  input  logic [NUM_HW_INT-1:0] int_in,
  input  logic                  exc_addr_err,
  input  logic                  exc_ri,
  input  logic                  exc_ov,
  input  logic                  exc_tr,
  input  logic                  exc_sys,
  input  logic                  exc_bp,
  input  logic [XLEN-1:0]       exc_bad_addr,
  input  logic [XLEN-1:0]       exc_pc,
  input  logic                  exc_is_bd,
  output logic                  exc_pc_sel,
  output logic [XLEN-1:0]       exc_pc_out,
  output logic [IP_W-1:0]       ip,
  output logic                  kernel_mode
);

  logic              status_ie, status_exl, status_um;
  logic [IP_W-1:0]   status_im;
  logic              cause_bd;
  logic [CODE_W-1:0] cause_code;
  logic [XLEN-1:0]   epc, badvaddr;

  logic              status_ie_d, status_exl_d, status_um_d;
  logic [IP_W-1:0]   status_im_d, ip_d;
  logic [1:0]        sw_ip_d;
  logic              cause_bd_d;
  logic [CODE_W-1:0] cause_code_d;
  logic [XLEN-1:0]   epc_d, badvaddr_d, reg_out_d, exc_pc_out_d;
  logic              exc_pc_sel_d, kernel_mode_d;

`ifdef CP0_TIMER_EN
  logic [XLEN-1:0]   count, compare, count_d, compare_d;
  logic              timer_ip, timer_ip_d;
`endif

  exc_sel_t          exc_c;
  logic              int_pend_c, wr_en_c;
  logic [XLEN-1:0]   rdata_c;

  // Interrupts are judged on the registered (pre-write) Status and Cause.IP.
  assign int_pend_c = status_ie & ~status_exl & (|(ip & status_im));
  // A write in the same cycle as any exception entry is dropped.
  assign wr_en_c    = mtc0 && (sel == '0) && !exc_c.taken;

  cp0_exc_prio u_prio (
    .addr_err (exc_addr_err),
    .ri       (exc_ri),
    .ov       (exc_ov),
    .tr       (exc_tr),
    .sys      (exc_sys),
    .bp       (exc_bp),
    .int_pend (int_pend_c),
    .exc_c    (exc_c)
  );

  // Read mux over current register state.
  always_comb begin
    rdata_c = '0;
    if (sel == '0) begin
      case (rd)
        REG_BADVADDR: rdata_c = badvaddr;
`ifdef CP0_TIMER_EN
        REG_COUNT:    rdata_c = count;
        REG_COMPARE:  rdata_c = compare;
`endif
        REG_STATUS:   rdata_c = pack_status(status_ie, status_exl, status_um, status_im);
        REG_CAUSE:    rdata_c = pack_cause(cause_bd, ip, cause_code);
        REG_EPC:      rdata_c = epc;
        default:      rdata_c = '0;
      endcase
    end
  end

  // Next-state: timer, MTC0, then exception entry / ERET override.
  always_comb begin
    status_ie_d  = status_ie;
    status_exl_d = status_exl;
    status_um_d  = status_um;
    status_im_d  = status_im;
    sw_ip_d      = ip[1:0];
    cause_bd_d   = cause_bd;
    cause_code_d = cause_code;
    epc_d        = epc;
    badvaddr_d   = badvaddr;
    exc_pc_sel_d = 1'b0;
    exc_pc_out_d = exc_pc_out;
    reg_out_d    = mfc0 ? rdata_c : reg_out;
`ifdef CP0_TIMER_EN
    count_d      = count + 32'd1;
    compare_d    = compare;
    timer_ip_d   = timer_ip | (count == compare);
`endif

    // BadVAddr is read-only; it is only loaded by address-error entry.
    if (wr_en_c) begin
      case (rd)
        REG_STATUS: begin
          status_ie_d  = reg_in[ST_IE];
          status_exl_d = reg_in[ST_EXL];
          status_um_d  = reg_in[ST_UM];
          status_im_d  = reg_in[ST_IM_LSB +: IP_W];
        end
        REG_CAUSE:  sw_ip_d = reg_in[CA_IP_LSB +: 2];
        REG_EPC:    epc_d   = reg_in;
`ifdef CP0_TIMER_EN
        REG_COUNT:  count_d = reg_in;
        REG_COMPARE: begin
          compare_d  = reg_in;
          timer_ip_d = 1'b0;
        end
`endif
        default: ;
      endcase
    end

    if (exc_c.taken) begin
      status_exl_d = 1'b1;
      cause_code_d = exc_c.code;
      cause_bd_d   = exc_is_bd;
      epc_d        = exc_is_bd ? (exc_pc - 32'd4) : exc_pc;
      if (exc_c.addr_err) badvaddr_d = exc_bad_addr;
      exc_pc_sel_d = 1'b1;
      exc_pc_out_d = EXC_VECTOR;
    end else if (eret) begin
      status_exl_d = 1'b0;
      exc_pc_sel_d = 1'b1;
      exc_pc_out_d = epc;
    end

    ip_d                      = '0;
    ip_d[1:0]                 = sw_ip_d;
    ip_d[2 +: NUM_HW_INT]     = int_in;
`ifdef CP0_TIMER_EN
    ip_d[IP_W-1]              = ip_d[IP_W-1] | timer_ip_d;
`endif
    kernel_mode_d = status_exl_d | ~status_um_d;
  end

  // State registers, synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      status_ie   <= 1'b0;
      status_exl  <= 1'b0;
      status_um   <= 1'b0;
      status_im   <= '0;
      ip          <= '0;
      cause_bd    <= 1'b0;
      cause_code  <= '0;
      epc         <= '0;
      badvaddr    <= '0;
      reg_out     <= '0;
      exc_pc_sel  <= 1'b0;
      exc_pc_out  <= '0;
      kernel_mode <= 1'b1;
`ifdef CP0_TIMER_EN
      count       <= '0;
      compare     <= '0;
      timer_ip    <= 1'b0;
`endif
    end else begin
      status_ie   <= status_ie_d;
      status_exl  <= status_exl_d;
      status_um   <= status_um_d;
      status_im   <= status_im_d;
      ip          <= ip_d;
      cause_bd    <= cause_bd_d;
      cause_code  <= cause_code_d;
      epc         <= epc_d;
      badvaddr    <= badvaddr_d;
      reg_out     <= reg_out_d;
      exc_pc_sel  <= exc_pc_sel_d;
      exc_pc_out  <= exc_pc_out_d;
      kernel_mode <= kernel_mode_d;
`ifdef CP0_TIMER_EN
      count       <= count_d;
      compare     <= compare_d;
      timer_ip    <= timer_ip_d;
`endif
    end
  end

endmodule

// File: tb/tb_cp0_core.sv
// Self-checking bench for cp0_core: directed scenarios then randomized traffic,
// every cycle compared against an architectural model of CP0.
module tb_cp0_core;

  localparam int unsigned NHW = 6;

  logic              clock, reset, mfc0, mtc0, eret;
  logic [4:0]        rd;
  logic [2:0]        sel;
  logic [31:0]       reg_in, reg_out;
  logic [NHW-1:0]    int_in;
  logic              exc_addr_err, exc_ri, exc_ov, exc_tr, exc_sys, exc_bp;
  logic [31:0]       exc_bad_addr, exc_pc;
  logic              exc_is_bd, exc_pc_sel, kernel_mode;
  logic [31:0]       exc_pc_out;
  logic [7:0]        ip;

  cp0_core #(.NUM_HW_INT(NHW), .EXC_VECTOR(32'h8000_0180)) dut (
    .clock(clock), .reset(reset), .mfc0(mfc0), .mtc0(mtc0), .eret(eret),
    .rd(rd), .sel(sel), .reg_in(reg_in), .reg_out(reg_out), .int_in(int_in),
    .exc_addr_err(exc_addr_err), .exc_ri(exc_ri), .exc_ov(exc_ov), .exc_tr(exc_tr),
    .exc_sys(exc_sys), .exc_bp(exc_bp), .exc_bad_addr(exc_bad_addr), .exc_pc(exc_pc),
    .exc_is_bd(exc_is_bd), .exc_pc_sel(exc_pc_sel), .exc_pc_out(exc_pc_out),
    .ip(ip), .kernel_mode(kernel_mode)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks, n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Architectural model state
  logic        m_ie, m_exl, m_um, m_bd, m_tip;
  logic [7:0]  m_im, m_hwip;
  logic [1:0]  m_swip;
  logic [4:0]  m_code;
  logic [31:0] m_epc, m_bad, m_count, m_compare;
  logic        e_sel, e_km;
  logic [31:0] e_pcout, e_regout;
  logic [7:0]  e_ip;

  function automatic logic [7:0] cur_ip();
    logic [7:0] v;
    v = {6'd0, m_swip} | m_hwip;
`ifdef CP0_TIMER_EN
    v[7] = v[7] | m_tip;
`endif
    return v;
  endfunction

  function automatic logic [31:0] rd_val(input logic [4:0] r, input logic [2:0] s);
    logic [31:0] v;
    v = 32'd0;
    if (s == 3'd0) begin
      case (r)
        5'd8:  v = m_bad;
`ifdef CP0_TIMER_EN
        5'd9:  v = m_count;
        5'd11: v = m_compare;
`endif
        5'd12: v = {16'd0, m_im, 3'd0, m_um, 2'd0, m_exl, m_ie};
        5'd13: v = {m_bd, 15'd0, cur_ip(), 1'b0, m_code, 2'b00};
        5'd14: v = m_epc;
        default: v = 32'd0;
      endcase
    end
    return v;
  endfunction

  task automatic model_reset();
    m_ie = 0; m_exl = 0; m_um = 0; m_bd = 0; m_tip = 0;
    m_im = 0; m_hwip = 0; m_swip = 0; m_code = 0;
    m_epc = 0; m_bad = 0; m_count = 0; m_compare = 0;
    e_sel = 0; e_pcout = 0; e_regout = 0;
  endtask

  task automatic clear_inputs();
    mfc0 = 0; mtc0 = 0; eret = 0; rd = 0; sel = 0; reg_in = 0;
    exc_addr_err = 0; exc_ri = 0; exc_ov = 0; exc_tr = 0; exc_sys = 0; exc_bp = 0;
    exc_bad_addr = 0; exc_pc = 0; exc_is_bd = 0;
  endtask

  // One clock: predict from current inputs, advance, compare all outputs.
  task automatic step();
    logic        pend, tk, aerr, wr;
    logic [4:0]  code;
    logic [31:0] rv, old_epc;
    pend = m_ie && !m_exl && ((cur_ip() & m_im) != 8'd0);
    tk = 1'b1; aerr = 1'b0; code = 5'd0;
    if (exc_addr_err) begin code = 5'd4; aerr = 1'b1; end
    else if (exc_ri)  code = 5'd10;
    else if (exc_ov)  code = 5'd12;
    else if (exc_tr)  code = 5'd13;
    else if (exc_sys) code = 5'd8;
    else if (exc_bp)  code = 5'd9;
    else if (pend)    code = 5'd0;
    else tk = 1'b0;
    rv      = rd_val(rd, sel);
    wr      = mtc0 && (sel == 3'd0) && !tk;
    old_epc = m_epc;
    @(posedge clock);
    if (!reset) begin
      model_reset();
    end else begin
`ifdef CP0_TIMER_EN
      if (m_count == m_compare) m_tip = 1'b1;
      m_count = m_count + 32'd1;
`endif
      m_hwip = 8'(int_in) << 2;
      if (wr) begin
        case (rd)
          5'd12: begin m_ie = reg_in[0]; m_exl = reg_in[1]; m_um = reg_in[4]; m_im = reg_in[15:8]; end
          5'd13: m_swip = reg_in[9:8];
          5'd14: m_epc = reg_in;
`ifdef CP0_TIMER_EN
          5'd9:  m_count = reg_in;
          5'd11: begin m_compare = reg_in; m_tip = 1'b0; end
`endif
          default: ;
        endcase
      end
      e_sel = 1'b0;
      if (tk) begin
        m_exl = 1'b1; m_code = code; m_bd = exc_is_bd;
        m_epc = exc_is_bd ? exc_pc - 32'd4 : exc_pc;
        if (aerr) m_bad = exc_bad_addr;
        e_sel = 1'b1; e_pcout = 32'h8000_0180;
      end else if (eret) begin
        m_exl = 1'b0; e_sel = 1'b1; e_pcout = old_epc;
      end
      if (mfc0) e_regout = rv;
    end
    e_ip = cur_ip();
    e_km = m_exl | ~m_um;
    #1;
    check("exc_pc_sel", 32'(exc_pc_sel), 32'(e_sel));
    if (e_sel) check("exc_pc_out", exc_pc_out, e_pcout);
    check("reg_out", reg_out, e_regout);
    check("ip", 32'(ip), 32'(e_ip));
    check("kernel_mode", 32'(kernel_mode), 32'(e_km));
  endtask

  task automatic read_reg(input logic [4:0] r);
    clear_inputs(); mfc0 = 1; rd = r; step(); clear_inputs();
  endtask

  task automatic write_reg(input logic [4:0] r, input logic [31:0] v);
    clear_inputs(); mtc0 = 1; rd = r; reg_in = v; step(); clear_inputs();
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    clear_inputs(); int_in = '0; reset = 0;
    model_reset();
    @(posedge clock); #1;
    step(); step();
    check("rst_kernel_mode", 32'(kernel_mode), 32'd1);
    check("rst_exc_pc_sel", 32'(exc_pc_sel), 32'd0);
    check("rst_exc_pc_out", exc_pc_out, 32'd0);
    check("rst_ip", 32'(ip), 32'd0);
    reset = 1;
    read_reg(5'd12);
    check("rst_status", reg_out, 32'd0);

    // syscall entry then ERET
    exc_sys = 1; exc_pc = 32'h0040_0010; step(); clear_inputs();
    check("sys_sel", 32'(exc_pc_sel), 32'd1);
    check("sys_vec", exc_pc_out, 32'h8000_0180);
    read_reg(5'd14); check("sys_epc", reg_out, 32'h0040_0010);
    read_reg(5'd13); check("sys_code", 32'(reg_out[6:2]), 32'd8);
    read_reg(5'd12); check("sys_exl", 32'(reg_out[1]), 32'd1);
    eret = 1; step(); clear_inputs();
    check("eret_sel", 32'(exc_pc_sel), 32'd1);
    check("eret_pc", exc_pc_out, 32'h0040_0010);
    step(); check("eret_sel_drop", 32'(exc_pc_sel), 32'd0);
    read_reg(5'd12); check("eret_exl", 32'(reg_out[1]), 32'd0);

    // priority: addr_err beats ov, in delay slot
    exc_addr_err = 1; exc_ov = 1; exc_is_bd = 1; exc_pc = 32'h100; exc_bad_addr = 32'h3;
    step(); clear_inputs();
    read_reg(5'd13);
    check("ae_code", 32'(reg_out[6:2]), 32'd4);
    check("ae_bd", 32'(reg_out[31]), 32'd1);
    read_reg(5'd14); check("ae_epc", reg_out, 32'hFC);
    read_reg(5'd8);  check("ae_badvaddr", reg_out, 32'h3);

    // hardware interrupt, two cycles from int_in to redirect, then masked by EXL
    write_reg(5'd12, 32'h0000_0401);
    int_in = 6'd1; step();
    check("int_sel_early", 32'(exc_pc_sel), 32'd0);
    step();
    check("int_sel", 32'(exc_pc_sel), 32'd1);
    check("int_vec", exc_pc_out, 32'h8000_0180);
    read_reg(5'd13); check("int_code", 32'(reg_out[6:2]), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(); check("int_masked", 32'(exc_pc_sel), 32'd0);
    end
    int_in = '0; step();

`ifdef CP0_TIMER_EN
    write_reg(5'd11, 32'd5);
    write_reg(5'd9, 32'd0);
    for (int i = 0; i < 5; i++) step();
    check("tmr_before", 32'(ip[7]), 32'd0);
    step();
    check("tmr_hit", 32'(ip[7]), 32'd1);
    write_reg(5'd11, 32'd1000);
    check("tmr_clear", 32'(ip[7]), 32'd0);
    write_reg(5'd9, 32'hFFFF_FFFF);
    step();
    read_reg(5'd9); check("tmr_wrap", reg_out, 32'd0);
`endif

    // MTC0 EPC dropped by simultaneous exception
    mtc0 = 1; rd = 5'd14; reg_in = 32'hDEAD_BEEF; exc_ri = 1; exc_pc = 32'h2000;
    step(); clear_inputs();
    read_reg(5'd14); check("ri_epc", reg_out, 32'h2000);

    // reset on the same edge as an exception suppresses the redirect
    exc_sys = 1; reset = 0; step(); clear_inputs();
    check("midrst_sel", 32'(exc_pc_sel), 32'd0);
    check("midrst_km", 32'(kernel_mode), 32'd1);
    reset = 1; step();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int r;
      clear_inputs();
      r = $urandom_range(99);
      if (r < 30) mtc0 = 1;
      else if (r < 38) eret = 1;
      mfc0 = 1'($urandom_range(1));
      case ($urandom_range(7))
        0: rd = 5'd8;  1: rd = 5'd9;  2: rd = 5'd11; 3: rd = 5'd12;
        4: rd = 5'd13; 5: rd = 5'd14; 6: rd = 5'($urandom); default: rd = 5'd12;
      endcase
      if (mtc0 && rd == 5'd8) rd = 5'd14;
      sel = ($urandom_range(9) == 0) ? 3'($urandom_range(7)) : 3'd0;
      reg_in = $urandom;
      if (rd == 5'd12 && $urandom_range(1) == 1) reg_in[1] = 1'b0;
      exc_addr_err = ($urandom_range(29) == 0);
      exc_ri       = ($urandom_range(29) == 0);
      exc_ov       = ($urandom_range(29) == 0);
      exc_tr       = ($urandom_range(29) == 0);
      exc_sys      = ($urandom_range(29) == 0);
      exc_bp       = ($urandom_range(29) == 0);
      exc_bad_addr = $urandom;
      exc_pc       = $urandom;
      exc_is_bd    = 1'($urandom_range(1));
      if ($urandom_range(7) == 0) int_in = NHW'($urandom);
      reset = ($urandom_range(199) == 0) ? 1'b0 : 1'b1;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
